vcc_wr_arbiter: RTL
===================

Name: vcc_wr_arbiter

Overview:
Round-robin arbiter that shares the single VALU write port of the per-wavefront VCC register file among NUM_PORTS vector requesters (SIMD0-3, SIMF0-3).
- Each requester uses a req/gnt handshake.
- The winner's write is registered and presented to the VCC file one cycle after grant.
- A VALU write is deferred when the SALU or fetch-init path writes the same wavefront in the same cycle.
- The block also reports the VALU VCC write to issue and flags starvation.

Parameters:
NUM_PORTS, 8, number of VALU requesters (2..16).
MAX_WAIT, 32, cycles a request may stay ungranted before starve_err sets.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
req  in  NUM_PORTS  bit i: port i requests a VCC write.
req_wfid  in  6*NUM_PORTS  bits [6i+5:6i]: wavefront id of port i.
req_data  in  64*NUM_PORTS  bits [64i+63:64i]: VCC value of port i.
gnt  out  NUM_PORTS  one-hot grant pulse.
salu_wr_vcc_en  in  1  SALU VCC write this cycle.
salu_wr_wfid  in  6  SALU write wavefront.
fetch_init_wf_en  in  1  wavefront init write this cycle.
fetch_init_wf_id  in  6  init wavefront.
vcc_wr_en  out  1  registered write enable to the VCC file.
vcc_wr_addr  out  6  registered wavefront id.
vcc_wr_data  out  64  registered VCC value.
issue_valu_wr_vcc_en  out  1  equals vcc_wr_en.
issue_valu_wr_vcc_wfid  out  6  equals vcc_wr_addr.
starve_err  out  1  sticky starvation flag.

Behaviour:
- Reset (rst==0 at a clock edge):
  - vcc_wr_en=0, vcc_wr_addr=0, vcc_wr_data=0.
  - Priority pointer ptr=0; all wait counters=0; starve_err=0.
  - gnt=0 while rst==0, regardless of req.
- Eligibility in cycle t: port i is eligible iff req[i]=1 and its wfid does not match any active same-cycle write:
  - not (salu_wr_vcc_en and req_wfid_i==salu_wr_wfid), and
  - not (fetch_init_wf_en and req_wfid_i==fetch_init_wf_id).
- Selection:
  - Combinational. Search starts at index ptr and wraps modulo NUM_PORTS; the first eligible port k wins.
  - gnt[k]=1 in cycle t; all other gnt bits are 0. If no port is eligible, gnt=0.
  - gnt is never asserted to a port whose req is 0.
- Requester handshake:
  - Requester holds req, wfid and data stable until it sees gnt.
  - The grant cycle consumes the request. If req stays high the next cycle, that is a new request.
  - Requester-side violations are checked by assertion only; the arbiter does not detect them.
- Pointer update: on any grant, ptr <= (k+1) mod NUM_PORTS at the end of cycle t. With no grant, ptr holds.
- Write output, latency 1:
  - At the edge ending cycle t: vcc_wr_en <= |gnt; vcc_wr_addr <= req_wfid_k; vcc_wr_data <= req_data_k.
  - With no grant: vcc_wr_en <= 0, and addr/data hold their previous values.
  - Throughput: one write per cycle, back to back.
- Starvation detection, per port i:
  - wait_i increments each cycle req[i]=1 and gnt[i]=0; it clears when gnt[i]=1 or req[i]=0.
  - The counter saturates at MAX_WAIT.
  - When wait_i reaches MAX_WAIT, starve_err <= 1. It clears only on reset.
  - Round robin bounds the wait to NUM_PORTS-1 cycles unless hazard deferral persists.
- Boundary cases:
  - All ports requesting: grants rotate ptr, ptr+1, … with no port granted twice within NUM_PORTS grants.
  - Single requester: granted every cycle it requests.
  - Hazard on the pointer port: search skips to the next eligible port; the deferred port keeps its request.
  - SALU and init both active on different wfids: both are masked.
  - Reset mid-stream: outstanding requests are not granted while rst==0. They are re-arbitrated from ptr=0 after reset deasserts, and the pending vcc_wr_en is dropped.

Test Plan:
1. Reset, then req=8'h01 with wfid0=5, data0=64'hA5A5, held 1 cycle -> gnt=8'h01 in that cycle; next cycle vcc_wr_en=1, addr=5, data=64'hA5A5, issue_valu_wr_vcc_en=1, issue_valu_wr_vcc_wfid=5.
2. req=8'hFF held continuously from ptr=0 -> gnt sequence 01,02,04,…,80,01; vcc_wr_en=1 every cycle from the second; starve_err stays 0.
3. req=8'h05, port0 wfid=3, salu_wr_vcc_en=1, salu_wr_wfid=3 -> gnt=8'h04; next cycle port0 granted (salu idle), and ptr then points to 1.
4. fetch_init_wf_en=1, id=7, and the only requester port2 has wfid=7 for 40 cycles (MAX_WAIT=32) -> gnt stays 0; starve_err=1 after 32 waiting cycles and stays 1 after the hazard clears, until reset.
5. req=8'hFF running, rst=0 for 1 cycle mid-stream -> gnt=0 and vcc_wr_en=0 the cycle after; after release, the first grant is port 0.
6. Random req/wfid/salu/init traffic for 10k cycles -> scoreboard: every request is written exactly once with the correct data, never in a same-wfid conflicting cycle; gnt is always one-hot-or-zero.

Source files
------------

// File: rtl/vcc_wr_arbiter.sv
// Round-robin arbiter for the single VALU write port of the VCC register file.
// Same-cycle SALU/init writes to the same wavefront defer a VALU requester.
module vcc_wr_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int MAX_WAIT  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [6*NUM_PORTS-1:0]  req_wfid,
  input  logic [64*NUM_PORTS-1:0] req_data,
  output logic [NUM_PORTS-1:0]    gnt,
  input  logic                    salu_wr_vcc_en,
  input  logic [5:0]              salu_wr_wfid,
  input  logic                    fetch_init_wf_en,
  input  logic [5:0]              fetch_init_wf_id,
  output logic                    vcc_wr_en,
  output logic [5:0]              vcc_wr_addr,
  output logic [63:0]             vcc_wr_data,
  output logic                    issue_valu_wr_vcc_en,
  output logic [5:0]              issue_valu_wr_vcc_wfid,
  output logic                    starve_err
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    return (v == WW'(MAX_WAIT)) ? v : v + WW'(1);
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] s);
    return (s == PW'(NUM_PORTS - 1)) ? '0 : s + PW'(1);
  endfunction

  logic [PW-1:0]        ptr;
  logic [NUM_PORTS-1:0] elig;
  logic [PW-1:0]        sel_p0;
  logic                 vld_p0;
  logic                 vld_p1;
  logic [5:0]           addr_p1;
  logic [63:0]          data_p1;
  logic [WW-1:0]        wait_cnt [NUM_PORTS];

  // Stage p0: hazard masking and round-robin search starting at ptr
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = req[i]
        && !(salu_wr_vcc_en   && (req_wfid[6*i +: 6] == salu_wr_wfid))
        && !(fetch_init_wf_en && (req_wfid[6*i +: 6] == fetch_init_wf_id));
    end
  end

  always_comb begin
    int idx;
    sel_p0 = '0;
    vld_p0 = 1'b0;
    idx    = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!vld_p0 && elig[PW'(idx)]) begin
        sel_p0 = PW'(idx);
        vld_p0 = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (rst && vld_p0) gnt[sel_p0] = 1'b1;
  end

  // Stage p1: registered write to the VCC file, pointer and wait counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr        <= '0;
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      data_p1    <= '0;
      starve_err <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        ptr     <= next_ptr(sel_p0);
        addr_p1 <= req_wfid[6*sel_p0 +: 6];
        data_p1 <= req_data[64*sel_p0 +: 64];
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!req[i] || gnt[i]) begin
          wait_cnt[i] <= '0;
        end else begin
          wait_cnt[i] <= sat_inc(wait_cnt[i]);
          if (sat_inc(wait_cnt[i]) == WW'(MAX_WAIT)) starve_err <= 1'b1;
        end
      end
    end
  end

  assign vcc_wr_en              = vld_p1;
  assign vcc_wr_addr            = addr_p1;
  assign vcc_wr_data            = data_p1;
  assign issue_valu_wr_vcc_en   = vld_p1;
  assign issue_valu_wr_vcc_wfid = addr_p1;

endmodule
